// File: rtl/exception_commit_pkg.sv
// ============================================================================
// exception_commit_pkg
// Shared definitions for the exception commit stage: ExcCode values,
// exception-vector bit positions, CP0 register numbers and FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package exception_commit_pkg;

  // 5-bit CP0 Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;
  localparam logic [4:0] EXC_ERET = 5'd14;

  // Bit positions inside a per-slot exception vector
  localparam int EXC_VEC_W    = 9;
  localparam int EV_ADEL_IF   = 0;
  localparam int EV_RI        = 1;
  localparam int EV_SYS       = 2;
  localparam int EV_BP        = 3;
  localparam int EV_TR        = 4;
  localparam int EV_OV        = 5;
  localparam int EV_ADEL_DATA = 6;
  localparam int EV_ADES      = 7;
  localparam int EV_ERET      = 8;

  // CP0 register numbers and selects that can be forwarded
  localparam logic [4:0] CP0_STATUS    = 5'd12;
  localparam logic [4:0] CP0_CAUSE     = 5'd13;
  localparam logic [4:0] CP0_EPC       = 5'd14;
  localparam logic [4:0] CP0_EBASE     = 5'd15;
  localparam logic [2:0] CP0_SEL_MAIN  = 3'd0;
  localparam logic [2:0] CP0_SEL_EBASE = 3'd1;

  // Commit-stage control states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/exc_prio_enc.sv
// ============================================================================
// exc_prio_enc
// Per-slot exception priority encoder: reduces a 9-bit exception vector to
// a hit flag and the ExcCode of the highest-priority pending exception.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exc_prio_enc
  import exception_commit_pkg::*;
(
  input  logic [EXC_VEC_W-1:0] exc_vec,
  output logic                 hit,
  output logic [4:0]           code
);

  // First match wins; fetch-side faults outrank execute and memory faults
  always_comb begin
    hit  = 1'b1;
    code = EXC_INT;
    if (exc_vec[EV_ADEL_IF])        code = EXC_ADEL;
    else if (exc_vec[EV_RI])        code = EXC_RI;
    else if (exc_vec[EV_SYS])       code = EXC_SYS;
    else if (exc_vec[EV_BP])        code = EXC_BP;
    else if (exc_vec[EV_OV])        code = EXC_OV;
    else if (exc_vec[EV_TR])        code = EXC_TR;
    else if (exc_vec[EV_ADEL_DATA]) code = EXC_ADEL;
    else if (exc_vec[EV_ADES])      code = EXC_ADES;
    else if (exc_vec[EV_ERET])      code = EXC_ERET;
    else                            hit  = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/exception_commit.sv
// ============================================================================
// exception_commit
// Registered exception arbitration between the dual-issue memory stage and
// CP0. Selects at most one exception per cycle (interrupt first, then the
// older slot), gates writeback of squashed slots, and drives flush/redirect.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exception_commit
  import exception_commit_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] EXC_OFFSET   = 32'h180
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 inst1_valid_i,
  input  logic                 inst2_valid_i,
  input  logic [EXC_VEC_W-1:0] inst1_exc_i,
  input  logic [EXC_VEC_W-1:0] inst2_exc_i,
  input  logic [31:0]          inst1_addr_i,
  input  logic [31:0]          inst2_addr_i,
  input  logic                 inst1_ds_i,
  input  logic                 inst2_ds_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [31:0]          cp0_status_i,
  input  logic [31:0]          cp0_cause_i,
  input  logic [31:0]          cp0_epc_i,
  input  logic [31:0]          cp0_ebase_i,
  input  logic                 cp0_we_i,
  input  logic [4:0]           cp0_waddr_i,
  input  logic [2:0]           cp0_wsel_i,
  input  logic [31:0]          cp0_wdata_i,
  output logic                 exception_flag_o,
  output logic [4:0]           exception_type_o,
  output logic                 exception_first_inst_o,
  output logic [31:0]          inst1_addr_o,
  output logic [31:0]          inst2_addr_o,
  output logic [31:0]          mem_addr_o,
  output logic                 is_in_delayslot1_o,
  output logic                 is_in_delayslot2_o,
  output logic                 inst1_commit_o,
  output logic                 inst2_commit_o,
  output logic                 flush_o,
  output logic [31:0]          new_pc_o
);

  // Counter reload value; FLUSH is left when the counter reads zero
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [2:0]  flush_cnt;

  logic [7:0]  im_fwd;
  logic        ie_fwd;
  logic        exl_fwd;
  logic [31:0] epc_fwd;
  logic [31:0] ebase_fwd;
  logic        int_pending;

  logic        slot1_live;
  logic        slot2_live;
  logic        hit1;
  logic        hit2;
  logic [4:0]  code1;
  logic [4:0]  code2;

  logic        take;
  logic [4:0]  take_code;
  logic        take_first;
  logic        commit1_nx;
  logic        commit2_nx;
  logic [31:0] target_pc;

  // Status bits and Cause bits that play no part in arbitration
  logic        unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                             cp0_cause_i[31:16], cp0_cause_i[7:0]};

  // Wrong-path slots during FLUSH behave exactly like empty slots
  assign slot1_live = inst1_valid_i && (state == ST_IDLE);
  assign slot2_live = inst2_valid_i && (state == ST_IDLE);

  exc_prio_enc u_prio_slot1 (
    .exc_vec (inst1_exc_i),
    .hit     (hit1),
    .code    (code1)
  );

  exc_prio_enc u_prio_slot2 (
    .exc_vec (inst2_exc_i),
    .hit     (hit2),
    .code    (code2)
  );

  // Bypass an MTC0 still in writeback so this cycle sees the new CP0 state
  always_comb begin
    im_fwd    = cp0_status_i[15:8];
    ie_fwd    = cp0_status_i[0];
    exl_fwd   = cp0_status_i[1];
    epc_fwd   = cp0_epc_i;
    ebase_fwd = cp0_ebase_i;
    if (cp0_we_i) begin
      if (cp0_wsel_i == CP0_SEL_MAIN && cp0_waddr_i == CP0_STATUS) begin
        im_fwd  = cp0_wdata_i[15:8];
        ie_fwd  = cp0_wdata_i[0];
        exl_fwd = cp0_wdata_i[1];
      end
      if (cp0_wsel_i == CP0_SEL_MAIN && cp0_waddr_i == CP0_EPC) begin
        epc_fwd = cp0_wdata_i;
      end
      if (cp0_wsel_i == CP0_SEL_EBASE && cp0_waddr_i == CP0_EBASE) begin
        ebase_fwd = cp0_wdata_i;
      end
    end
  end

  assign int_pending = (|(cp0_cause_i[15:8] & im_fwd)) && ie_fwd && !exl_fwd;

  // Arbitrate: interrupt on the oldest live slot, else slot 1, else slot 2
  always_comb begin
    take       = 1'b0;
    take_code  = EXC_INT;
    take_first = 1'b0;
    commit1_nx = slot1_live;
    commit2_nx = slot2_live;
    if (int_pending && (slot1_live || slot2_live)) begin
      take       = 1'b1;
      take_code  = EXC_INT;
      take_first = slot1_live;
      commit1_nx = 1'b0;
      commit2_nx = 1'b0;
    end else if (slot1_live && hit1) begin
      take       = 1'b1;
      take_code  = code1;
      take_first = 1'b1;
      commit1_nx = 1'b0;
      commit2_nx = 1'b0;
    end else if (slot2_live && hit2) begin
      take       = 1'b1;
      take_code  = code2;
      take_first = 1'b0;
      commit1_nx = slot1_live;
      commit2_nx = 1'b0;
    end
  end

  // ERET returns to EPC; every other exception enters the general vector
  assign target_pc = (take_code == EXC_ERET) ? epc_fwd : (ebase_fwd + EXC_OFFSET);

  // Control FSM plus all registered outputs toward CP0 and the pipeline
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                  <= ST_IDLE;
      flush_cnt              <= 3'd0;
      exception_flag_o       <= 1'b0;
      exception_type_o       <= 5'd0;
      exception_first_inst_o <= 1'b0;
      inst1_addr_o           <= 32'd0;
      inst2_addr_o           <= 32'd0;
      mem_addr_o             <= 32'd0;
      is_in_delayslot1_o     <= 1'b0;
      is_in_delayslot2_o     <= 1'b0;
      inst1_commit_o         <= 1'b0;
      inst2_commit_o         <= 1'b0;
      flush_o                <= 1'b0;
      new_pc_o               <= 32'd0;
    end else begin
      exception_flag_o       <= take;
      exception_type_o       <= take_code;
      exception_first_inst_o <= take_first;
      inst1_addr_o           <= inst1_addr_i;
      inst2_addr_o           <= inst2_addr_i;
      mem_addr_o             <= mem_addr_i;
      is_in_delayslot1_o     <= inst1_ds_i;
      is_in_delayslot2_o     <= inst2_ds_i;
      inst1_commit_o         <= commit1_nx;
      inst2_commit_o         <= commit2_nx;
      case (state)
        ST_IDLE: begin
          if (take) begin
            state     <= ST_FLUSH;
            flush_cnt <= FLUSH_LOAD;
            flush_o   <= 1'b1;
            new_pc_o  <= target_pc;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 3'd0) begin
            state   <= ST_IDLE;
            flush_o <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          flush_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exception_commit.sv
// ============================================================================
// tb_exception_commit
// Self-checking bench for exception_commit with directed scenarios and a
// randomized run compared against a behavioural reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exception_commit;

  localparam int FC = 3;
  localparam int ORDER [9] = '{0, 1, 2, 3, 5, 4, 6, 7, 8};
  localparam int CODES [9] = '{4, 10, 8, 9, 12, 13, 4, 5, 14};

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst1_valid_i, inst2_valid_i;
  logic [8:0]  inst1_exc_i, inst2_exc_i;
  logic [31:0] inst1_addr_i, inst2_addr_i, mem_addr_i;
  logic        inst1_ds_i, inst2_ds_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [2:0]  cp0_wsel_i;
  logic [31:0] cp0_wdata_i;

  logic        exception_flag_o, exception_first_inst_o;
  logic [4:0]  exception_type_o;
  logic [31:0] inst1_addr_o, inst2_addr_o, mem_addr_o, new_pc_o;
  logic        is_in_delayslot1_o, is_in_delayslot2_o;
  logic        inst1_commit_o, inst2_commit_o, flush_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state and expected outputs
  int          blocked;
  logic [31:0] m_new_pc;
  logic        e_flag, e_first, e_c1, e_c2, e_flush, e_ds1, e_ds2;
  logic [4:0]  e_type;
  logic [31:0] e_a1, e_a2, e_mem, e_new_pc;

  exception_commit #(.FLUSH_CYCLES(FC), .EXC_OFFSET(32'h180)) dut (
    .clk(clk), .resetn(resetn),
    .inst1_valid_i(inst1_valid_i), .inst2_valid_i(inst2_valid_i),
    .inst1_exc_i(inst1_exc_i), .inst2_exc_i(inst2_exc_i),
    .inst1_addr_i(inst1_addr_i), .inst2_addr_i(inst2_addr_i),
    .inst1_ds_i(inst1_ds_i), .inst2_ds_i(inst2_ds_i),
    .mem_addr_i(mem_addr_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .cp0_ebase_i(cp0_ebase_i),
    .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i),
    .cp0_wsel_i(cp0_wsel_i), .cp0_wdata_i(cp0_wdata_i),
    .exception_flag_o(exception_flag_o), .exception_type_o(exception_type_o),
    .exception_first_inst_o(exception_first_inst_o),
    .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o),
    .mem_addr_o(mem_addr_o),
    .is_in_delayslot1_o(is_in_delayslot1_o), .is_in_delayslot2_o(is_in_delayslot2_o),
    .inst1_commit_o(inst1_commit_o), .inst2_commit_o(inst2_commit_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void prio(input logic [8:0] v, output logic hit, output logic [4:0] code);
    hit  = 1'b0;
    code = 5'd0;
    for (int i = 0; i < 9; i++) begin
      if (!hit && v[ORDER[i]]) begin
        hit  = 1'b1;
        code = 5'(CODES[i]);
      end
    end
  endfunction

  // Behavioural model of one clock edge, evaluated on the inputs about to be sampled
  task automatic model_step();
    logic [31:0] st, epcf, ebf;
    logic        h1, h2, live1, live2, intp, take;
    logic [4:0]  c1, c2, code;
    if (!resetn) begin
      {e_flag, e_first, e_c1, e_c2, e_flush, e_ds1, e_ds2} = '0;
      e_type = '0; e_a1 = '0; e_a2 = '0; e_mem = '0; e_new_pc = '0;
      blocked = 0; m_new_pc = '0;
      return;
    end
    st = cp0_status_i; epcf = cp0_epc_i; ebf = cp0_ebase_i;
    if (cp0_we_i && cp0_wsel_i == 3'd0 && cp0_waddr_i == 5'd12) begin
      st[15:8] = cp0_wdata_i[15:8];
      st[1:0]  = cp0_wdata_i[1:0];
    end
    if (cp0_we_i && cp0_wsel_i == 3'd0 && cp0_waddr_i == 5'd14) epcf = cp0_wdata_i;
    if (cp0_we_i && cp0_wsel_i == 3'd1 && cp0_waddr_i == 5'd15) ebf = cp0_wdata_i;
    intp  = ((cp0_cause_i[15:8] & st[15:8]) != 8'd0) && st[0] && !st[1];
    live1 = inst1_valid_i && (blocked == 0);
    live2 = inst2_valid_i && (blocked == 0);
    prio(inst1_exc_i, h1, c1);
    prio(inst2_exc_i, h2, c2);
    take = 1'b0; code = 5'd0; e_first = 1'b0; e_c1 = live1; e_c2 = live2;
    if (intp && (live1 || live2)) begin
      take = 1'b1; code = 5'd0; e_first = live1; e_c1 = 1'b0; e_c2 = 1'b0;
    end else if (live1 && h1) begin
      take = 1'b1; code = c1; e_first = 1'b1; e_c1 = 1'b0; e_c2 = 1'b0;
    end else if (live2 && h2) begin
      take = 1'b1; code = c2; e_first = 1'b0; e_c1 = live1; e_c2 = 1'b0;
    end
    e_flag = take;
    e_type = code;
    if (take) begin
      blocked  = FC;
      m_new_pc = (code == 5'd14) ? epcf : ebf + 32'h180;
    end else if (blocked > 0) begin
      blocked--;
    end
    e_flush  = (blocked > 0);
    e_new_pc = m_new_pc;
    e_a1 = inst1_addr_i; e_a2 = inst2_addr_i; e_mem = mem_addr_i;
    e_ds1 = inst1_ds_i; e_ds2 = inst2_ds_i;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst1_valid_i = 1'b0; inst2_valid_i = 1'b0;
    inst1_exc_i = '0; inst2_exc_i = '0;
    inst1_addr_i = 32'hBFC0_0100; inst2_addr_i = 32'hBFC0_0104;
    inst1_ds_i = 1'b0; inst2_ds_i = 1'b0;
    mem_addr_i = 32'h8000_2000;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0;
    cp0_epc_i = 32'hBFC0_0000; cp0_ebase_i = 32'h8000_0000;
    cp0_we_i = 1'b0; cp0_waddr_i = '0; cp0_wsel_i = '0; cp0_wdata_i = '0;
  endtask

  task automatic drain();
    clear_inputs();
    repeat (FC + 1) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    inst1_valid_i = 1'b1; inst1_exc_i = 9'h002; inst1_ds_i = 1'b1;
    tick();
    n_cmp++; if ({exception_flag_o, exception_first_inst_o, inst1_commit_o, inst2_commit_o, flush_o} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {exception_flag_o, exception_first_inst_o, inst1_commit_o, inst2_commit_o, flush_o}); end
    n_cmp++; if (exception_type_o !== 5'd0 || new_pc_o !== 32'd0) begin n_fail++; $display("FAIL reset_type_pc: got type=%0d pc=%h expected 0/0", exception_type_o, new_pc_o); end
    n_cmp++; if ({inst1_addr_o, inst2_addr_o, mem_addr_o} !== 96'd0 || {is_in_delayslot1_o, is_in_delayslot2_o} !== 2'b00) begin n_fail++; $display("FAIL reset_copies: got %h %h %h expected zeros", inst1_addr_o, inst2_addr_o, mem_addr_o); end
    resetn = 1'b1;
    clear_inputs();
    tick();
  endtask

  task automatic test_slot1_priority();
    int flush_len;
    int extra_flags;
    clear_inputs();
    inst1_valid_i = 1'b1; inst2_valid_i = 1'b1;
    inst1_exc_i = 9'h002;   // RI
    inst2_exc_i = 9'h004;   // SYS
    tick();
    n_cmp++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd10) begin n_fail++; $display("FAIL s1_ri_type: got flag=%b type=%0d expected 1/10", exception_flag_o, exception_type_o); end
    n_cmp++; if (exception_first_inst_o !== 1'b1 || {inst1_commit_o, inst2_commit_o} !== 2'b00) begin n_fail++; $display("FAIL s1_ri_commit: got first=%b commits=%b%b expected 1/00", exception_first_inst_o, inst1_commit_o, inst2_commit_o); end
    n_cmp++; if (new_pc_o !== 32'h8000_0180 || flush_o !== 1'b1) begin n_fail++; $display("FAIL s1_ri_pc: got pc=%h flush=%b expected 80000180/1", new_pc_o, flush_o); end
    clear_inputs();
    flush_len = 1; extra_flags = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (exception_flag_o) extra_flags++;
      if (!flush_o) break;
      flush_len++;
    end
    n_cmp++; if (flush_len !== FC) begin n_fail++; $display("FAIL flush_len: got %0d cycles expected %0d", flush_len, FC); end
    n_cmp++; if (extra_flags !== 0) begin n_fail++; $display("FAIL flag_pulse: got %0d extra flags expected 0", extra_flags); end
    drain();
  endtask

  task automatic test_slot2_and_back_to_back();
    clear_inputs();
    inst1_valid_i = 1'b1; inst2_valid_i = 1'b1;
    inst2_exc_i = 9'h020;   // OV
    tick();
    n_cmp++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd12 || exception_first_inst_o !== 1'b0) begin n_fail++; $display("FAIL s2_ov: got flag=%b type=%0d first=%b expected 1/12/0", exception_flag_o, exception_type_o, exception_first_inst_o); end
    n_cmp++; if ({inst1_commit_o, inst2_commit_o} !== 2'b10) begin n_fail++; $display("FAIL s2_ov_commit: got %b%b expected 10", inst1_commit_o, inst2_commit_o); end
    inst2_exc_i = 9'h000;
    inst1_exc_i = 9'h001;   // ADEL fetch, arrives during FLUSH
    tick();
    n_cmp++; if (exception_flag_o !== 1'b0 || {inst1_commit_o, inst2_commit_o} !== 2'b00) begin n_fail++; $display("FAIL b2b_ignored: got flag=%b commits=%b%b expected 0/00", exception_flag_o, inst1_commit_o, inst2_commit_o); end
    drain();
  endtask

  task automatic test_eret_forward();
    clear_inputs();
    inst1_valid_i = 1'b1;
    inst1_exc_i = 9'h100;   // ERET
    cp0_epc_i = 32'h1234_5678;
    cp0_we_i = 1'b1; cp0_waddr_i = 5'd14; cp0_wsel_i = 3'd0; cp0_wdata_i = 32'h8000_1000;
    tick();
    n_cmp++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd14) begin n_fail++; $display("FAIL eret_type: got flag=%b type=%0d expected 1/14", exception_flag_o, exception_type_o); end
    n_cmp++; if (new_pc_o !== 32'h8000_1000) begin n_fail++; $display("FAIL eret_pc: got %h expected 80001000", new_pc_o); end
    drain();
    inst2_valid_i = 1'b1;
    inst2_exc_i = 9'h080;   // ADES with forwarded EBase
    cp0_we_i = 1'b1; cp0_waddr_i = 5'd15; cp0_wsel_i = 3'd1; cp0_wdata_i = 32'h9000_0000;
    tick();
    n_cmp++; if (exception_type_o !== 5'd5 || new_pc_o !== 32'h9000_0180) begin n_fail++; $display("FAIL ebase_fwd: got type=%0d pc=%h expected 5/90000180", exception_type_o, new_pc_o); end
    drain();
  endtask

  task automatic test_interrupt();
    clear_inputs();
    cp0_status_i = 32'h0000_0401;
    cp0_cause_i  = 32'h0000_0400;
    inst2_valid_i = 1'b1;
    inst2_exc_i = 9'h004;   // SYS is outranked by the interrupt
    tick();
    n_cmp++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd0) begin n_fail++; $display("FAIL int_type: got flag=%b type=%0d expected 1/0", exception_flag_o, exception_type_o); end
    n_cmp++; if (exception_first_inst_o !== 1'b0 || {inst1_commit_o, inst2_commit_o} !== 2'b00) begin n_fail++; $display("FAIL int_slot: got first=%b commits=%b%b expected 0/00", exception_first_inst_o, inst1_commit_o, inst2_commit_o); end
    drain();
    cp0_status_i = 32'h0000_0403;   // EXL masks
    cp0_cause_i  = 32'h0000_0400;
    inst2_valid_i = 1'b1;
    tick();
    n_cmp++; if (exception_flag_o !== 1'b0 || {inst1_commit_o, inst2_commit_o} !== 2'b01) begin n_fail++; $display("FAIL int_exl: got flag=%b commits=%b%b expected 0/01", exception_flag_o, inst1_commit_o, inst2_commit_o); end
    cp0_status_i = 32'h0000_0401;
    cp0_we_i = 1'b1; cp0_waddr_i = 5'd12; cp0_wsel_i = 3'd0; cp0_wdata_i = 32'h0000_0400;
    tick();
    n_cmp++; if (exception_flag_o !== 1'b0 || flush_o !== 1'b0) begin n_fail++; $display("FAIL int_fwd_ie: got flag=%b flush=%b expected 0/0", exception_flag_o, flush_o); end
    drain();
  endtask

  task automatic test_reset_mid_flush();
    clear_inputs();
    inst1_valid_i = 1'b1;
    inst1_exc_i = 9'h004;   // SYS
    tick();
    clear_inputs();
    tick();
    n_cmp++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL midflush_pre: got flush=%b expected 1", flush_o); end
    resetn = 1'b0;
    tick();
    n_cmp++; if ({exception_flag_o, flush_o, inst1_commit_o, inst2_commit_o} !== 4'b0 || new_pc_o !== 32'd0 || inst1_addr_o !== 32'd0) begin n_fail++; $display("FAIL midflush_reset: got flag=%b flush=%b pc=%h expected 0/0/0", exception_flag_o, flush_o, new_pc_o); end
    resetn = 1'b1;
    inst1_valid_i = 1'b1;
    inst1_exc_i = 9'h008;   // BP
    tick();
    n_cmp++; if (exception_flag_o !== 1'b1 || exception_type_o !== 5'd9 || flush_o !== 1'b1) begin n_fail++; $display("FAIL after_reset: got flag=%b type=%0d flush=%b expected 1/9/1", exception_flag_o, exception_type_o, flush_o); end
    drain();
  endtask

  function automatic logic [8:0] rand_vec();
    logic [8:0] v;
    for (int b = 0; b < 9; b++) v[b] = ($urandom_range(0, 13) == 0);
    return v;
  endfunction

  task automatic test_random();
    int bad;
    bad = 0;
    for (int n = 0; n < 600; n++) begin
      inst1_valid_i = ($urandom_range(0, 3) != 0);
      inst2_valid_i = ($urandom_range(0, 3) != 0);
      inst1_exc_i = rand_vec();
      inst2_exc_i = rand_vec();
      inst1_addr_i = $urandom; inst2_addr_i = $urandom; mem_addr_i = $urandom;
      inst1_ds_i = 1'($urandom); inst2_ds_i = 1'($urandom);
      cp0_status_i = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
      cp0_cause_i  = ($urandom_range(0, 5) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
      cp0_epc_i = $urandom; cp0_ebase_i = {$urandom_range(0, 65535), 16'h0};
      cp0_we_i = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: cp0_waddr_i = 5'd12;
        1: cp0_waddr_i = 5'd14;
        2: cp0_waddr_i = 5'd15;
        default: cp0_waddr_i = 5'($urandom);
      endcase
      cp0_wsel_i = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd1;
      cp0_wdata_i = {$urandom_range(0, 65535), 8'($urandom), 6'h0, 2'($urandom)};
      tick();
      n_cmp++; if ({exception_flag_o, exception_type_o, exception_first_inst_o} !== {e_flag, e_type, e_first}) begin n_fail++; bad++; if (bad < 10) $display("FAIL rnd_exc[%0d]: got %b/%0d/%b expected %b/%0d/%b", n, exception_flag_o, exception_type_o, exception_first_inst_o, e_flag, e_type, e_first); end
      n_cmp++; if ({inst1_commit_o, inst2_commit_o, flush_o} !== {e_c1, e_c2, e_flush}) begin n_fail++; bad++; if (bad < 10) $display("FAIL rnd_ctrl[%0d]: got c=%b%b f=%b expected c=%b%b f=%b", n, inst1_commit_o, inst2_commit_o, flush_o, e_c1, e_c2, e_flush); end
      if (e_flush) begin
        n_cmp++; if (new_pc_o !== e_new_pc) begin n_fail++; bad++; if (bad < 10) $display("FAIL rnd_pc[%0d]: got %h expected %h", n, new_pc_o, e_new_pc); end
      end
      n_cmp++; if ({inst1_addr_o, inst2_addr_o, mem_addr_o, is_in_delayslot1_o, is_in_delayslot2_o} !== {e_a1, e_a2, e_mem, e_ds1, e_ds2}) begin n_fail++; bad++; if (bad < 10) $display("FAIL rnd_copy[%0d]: got %h %h %h expected %h %h %h", n, inst1_addr_o, inst2_addr_o, mem_addr_o, e_a1, e_a2, e_mem); end
    end
    drain();
  endtask

  initial begin
    resetn = 1'b0;
    blocked = 0;
    m_new_pc = '0;
    clear_inputs();
    test_reset();
    test_slot1_priority();
    test_slot2_and_back_to_back();
    test_eret_forward();
    test_interrupt();
    test_reset_mid_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exception_commit.md
# exception_commit

Registered exception-arbitration stage between the dual-issue memory stage and the CP0 register file. Each cycle it takes per-slot exception vectors for the two instructions in the memory stage, plus the pending-interrupt condition. It picks at most one exception, registers the result for CP0, gates writeback of squashed instructions, and drives the pipeline flush and redirect PC.

## Interface
- FLUSH_CYCLES, 1: cycles `flush_o` is held after a taken exception/ERET (1..7)
- EXC_OFFSET, 32'h180: offset added to EBase for the general exception vector
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- inst1_valid_i / inst2_valid_i  in  1  slot holds a real instruction
- inst1_exc_i / inst2_exc_i  in  9  exception vector: [0]ADEL-fetch [1]RI [2]SYS [3]BP [4]TR [5]OV [6]ADEL-data [7]ADES [8]ERET
- inst1_addr_i / inst2_addr_i  in  32  slot PCs
- inst1_ds_i / inst2_ds_i  in  1  slot is in a delay slot
- mem_addr_i  in  32  data address of the memory op
- cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_ebase_i  in  32 each  current CP0 values
- cp0_we_i  in  1  in-flight MTC0 write, from writeback
- cp0_waddr_i  in  5  in-flight MTC0 register address
- cp0_wsel_i  in  3  in-flight MTC0 select
- cp0_wdata_i  in  32  in-flight MTC0 data
- exception_flag_o  out  1  registered; to CP0
- exception_type_o  out  5  registered; to CP0
- exception_first_inst_o  out  1  registered; to CP0
- inst1_addr_o, inst2_addr_o, mem_addr_o  out  32  registered copies, to CP0
- is_in_delayslot1_o, is_in_delayslot2_o  out  1  registered copies
- inst1_commit_o, inst2_commit_o  out  1  registered writeback enables
- flush_o  out  1  kill all younger stages
- new_pc_o  out  32  redirect target, valid while `flush_o`

## Operation
- Forwarding: if `cp0_we_i` and `cp0_wsel_i`=0, `cp0_wdata_i` replaces the CP0 input when `cp0_waddr_i` is:
  - 12: Status bits [15:8] and [1:0]
  - 14: EPC
  - If `cp0_wsel_i`=1 and `cp0_waddr_i`=15: EBase is replaced.
- Interrupt pending: `(cause[15:8] & status[15:8]) != 0`, `status[0]`=1, `status[1]`=0, using forwarded values.
- Per-slot priority, first match wins: ADEL-fetch(4) > RI(10) > SYS(8) > BP(9) > OV(12) > TR(13) > ADEL-data(4) > ADES(5) > ERET(14). Codes are 5-bit ExcCode.
- Interrupt (code 0) outranks everything and attaches to the oldest valid slot.
- Slot order:
  - Slot 1 is older.
  - An exception in slot 1 gives `first_inst`=1 and both commits 0.
  - An exception only in slot 2 gives `first_inst`=0, `inst1_commit`=1, `inst2_commit`=0.
  - An invalid slot is never the source of an exception and its commit is 0.
- Target: `new_pc` = forwarded EPC for ERET, otherwise forwarded EBase + EXC_OFFSET.
- FSM:
  - IDLE: a taken exception/ERET moves to FLUSH with the counter loaded to FLUSH_CYCLES-1.
  - FLUSH: all slot inputs are treated as invalid (wrong path), with no exceptions and no commits. The counter decrements; at 0 the FSM returns to IDLE.
- No exception: flag=0, commits equal the valid bits, and the other registered outputs track their inputs.

## Timing
- Latency 1: inputs sampled at edge N appear on outputs after N. CP0 updates at edge N+1.
- `flush_o` and `new_pc_o` are registered alongside `exception_flag_o`. `flush_o` is high for exactly FLUSH_CYCLES consecutive cycles.
- `exception_flag_o` is a 1-cycle pulse per exception.
- Back-to-back: an exception at the input in the cycle after a taken one is ignored because the FSM is in FLUSH.
- Reset (also mid-FLUSH): state IDLE, counter 0, all outputs 0 including `new_pc_o`.

## Structure
- Shared defines package: ExcCode constants (INT, ADEL, ADES, SYS, BP, RI, OV, TR, ERET=14), exception-vector bit indices, CP0 register numbers.
- Sub-module `exc_prio_enc`: 9-bit vector to {hit, 5-bit code}, combinational, instantiated once per slot.

## Test plan
- Slot 1 RI, slot 2 SYS, both valid:
  - Next cycle: flag=1, type=10, first=1, commits 00, `new_pc`=EBase+0x180.
  - `flush_o` high FLUSH_CYCLES cycles.
- Slot 1 clean, slot 2 OV:
  - type=12, first=0, commits 10.
  - An exception presented during FLUSH produces no flag.
- ERET in slot 1 while MTC0 EPC=0x8000_1000 is in flight:
  - type=14, `new_pc`=0x8000_1000.
- Interrupt pending (status=0x0000_0401, cause IP2 set), slot 1 invalid, slot 2 valid:
  - type=0, first=0, commits 00.
- Interrupt masked by EXL=1, or forwarded MTC0 Status clearing IE: no flag.
- Reset asserted mid-FLUSH with FLUSH_CYCLES=3: all outputs 0 next cycle. An exception right after reset release is accepted.
